// File: rtl/inet_udp_rx_parser.sv
// inet_udp_rx_parser: streaming parser for the 44-byte pad/Ethernet/IPv4/UDP header stack.
// Captures header fields, validates IPv4 (IHL=5) carrying UDP, forwards only the UDP payload
// and counts dropped frames with a saturating counter.
// Optional IPv4 header checksum check: define INET_UDP_RX_CSUM_CHECK_EN.
module inet_udp_rx_parser #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              hdr_valid,
    output logic [47:0]       hdr_dst_mac,
    output logic [47:0]       hdr_src_mac,
    output logic [31:0]       hdr_src_ip,
    output logic [31:0]       hdr_dst_ip,
    output logic [15:0]       hdr_src_port,
    output logic [15:0]       hdr_dst_port,
    output logic [15:0]       hdr_udp_len,
    output logic              drop_pulse,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int unsigned NB        = DATA_W / 8;
    localparam int unsigned HDR_BYTES = 44;
    localparam int unsigned HDR_BEATS = HDR_BYTES / NB;
    localparam int unsigned BEAT_W    = 6;

    generate
        if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_width
            $error("inet_udp_rx_parser: DATA_W must be 8, 16 or 32");
        end
    endgenerate

    typedef enum logic [1:0] {StHdr, StPayload, StDrop} state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] wr_off;
    logic [7:0]        hdr_q    [HDR_BYTES];
    logic [7:0]        hdr_full [HDR_BYTES];
    logic              s_hs;
    logic              last_hdr_beat;
    logic              hdr_done;
    logic              runt;
    logic              checks_ok;
    logic              csum_ok;
    logic              accept;
    logic              reject;

    assign s_hs          = s_tvalid & s_tready;
    assign last_hdr_beat = (beat_q == BEAT_W'(HDR_BEATS - 1));
    assign hdr_done      = (state_q == StHdr) && s_hs && last_hdr_beat;
    assign runt          = (state_q == StHdr) && s_hs && s_tlast && !last_hdr_beat;
    assign wr_off        = beat_q * BEAT_W'(NB);
    assign m_tdata       = s_tdata;

    // Header view for the final beat: stored bytes plus the lanes arriving right now
    always_comb begin
        for (int i = 0; i < HDR_BYTES; i++) begin
            hdr_full[i] = hdr_q[i];
        end
        for (int k = 0; k < NB; k++) begin
            hdr_full[HDR_BYTES - NB + k] = s_tdata[8*k +: 8];
        end
    end

`ifdef INET_UDP_RX_CSUM_CHECK_EN
    logic [19:0] csum_sum;
    logic [16:0] csum_f1;
    logic [15:0] csum_f2;

    // Ones-complement sum of the ten IPv4 header words, folded twice for end-around carry
    always_comb begin
        csum_sum = '0;
        for (int w = 0; w < 10; w++) begin
            csum_sum = csum_sum + 20'({hdr_full[16 + 2*w], hdr_full[17 + 2*w]});
        end
        csum_f1 = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
        csum_f2 = csum_f1[15:0] + 16'(csum_f1[16]);
    end

    assign csum_ok = (csum_f2 == 16'hFFFF);
`else
    assign csum_ok = 1'b1;
`endif

    assign checks_ok = (hdr_full[14] == 8'h08) && (hdr_full[15] == 8'h00) &&
                       (hdr_full[16] == 8'h45) && (hdr_full[25] == 8'h11) && csum_ok;
    assign accept    = hdr_done && checks_ok;
    assign reject    = (hdr_done && !checks_ok) || runt;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StHdr;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHdr: begin
                if (hdr_done && !s_tlast) begin
                    state_d = checks_ok ? StPayload : StDrop;
                end
            end
            StPayload, StDrop: begin
                if (s_hs && s_tlast) begin
                    state_d = StHdr;
                end
            end
            default: state_d = StHdr;
        endcase
    end

    // FSM outputs: header and drop phases never back-pressure, payload passes straight through
    always_comb begin
        s_tready = 1'b1;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        unique case (state_q)
            StPayload: begin
                s_tready = m_tready;
                m_tvalid = s_tvalid;
                m_tlast  = s_tlast;
            end
            StHdr, StDrop: begin
                s_tready = 1'b1;
            end
            default: s_tready = 1'b1;
        endcase
    end

    // Beat counter: only advances in the header phase, zero on any (re)entry into it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_q <= '0;
        end else if (state_q != StHdr) begin
            beat_q <= '0;
        end else if (s_hs) begin
            if (last_hdr_beat || s_tlast) begin
                beat_q <= '0;
            end else begin
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

    // Header byte store, written at offset beat*NB
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < HDR_BYTES; i++) begin
                hdr_q[i] <= '0;
            end
        end else if (state_q == StHdr && s_hs) begin
            for (int k = 0; k < NB; k++) begin
                hdr_q[wr_off + BEAT_W'(k)] <= s_tdata[8*k +: 8];
            end
        end
    end

    // Field outputs load only for accepted frames and hold otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdr_dst_mac  <= '0;
            hdr_src_mac  <= '0;
            hdr_src_ip   <= '0;
            hdr_dst_ip   <= '0;
            hdr_src_port <= '0;
            hdr_dst_port <= '0;
            hdr_udp_len  <= '0;
        end else if (accept) begin
            hdr_dst_mac  <= {hdr_full[2], hdr_full[3], hdr_full[4],
                             hdr_full[5], hdr_full[6], hdr_full[7]};
            hdr_src_mac  <= {hdr_full[8], hdr_full[9], hdr_full[10],
                             hdr_full[11], hdr_full[12], hdr_full[13]};
            hdr_src_ip   <= {hdr_full[28], hdr_full[29], hdr_full[30], hdr_full[31]};
            hdr_dst_ip   <= {hdr_full[32], hdr_full[33], hdr_full[34], hdr_full[35]};
            hdr_src_port <= {hdr_full[36], hdr_full[37]};
            hdr_dst_port <= {hdr_full[38], hdr_full[39]};
            hdr_udp_len  <= {hdr_full[40], hdr_full[41]};
        end
    end

    // Registered status pulses and saturating drop counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hdr_valid  <= 1'b0;
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            hdr_valid  <= accept;
            drop_pulse <= reject;
            if (reject && drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inet_udp_rx_parser.sv
// Directed bench for inet_udp_rx_parser: DATA_W=32 main instance, plus DATA_W=16 and
// DATA_W=8 (CNT_W=2) instances for lane-width and counter-saturation cases.
module tb_inet_udp_rx_parser;

`ifdef INET_UDP_RX_CSUM_CHECK_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // DATA_W=32 instance
    logic [31:0] d32 = '0, md32;
    logic v32 = 0, l32 = 0, r32, mv32, ml32, hv32, dp32;
    logic mr = 1'b1;
    logic [47:0] dmac32, smac32;
    logic [31:0] sip32, dip32;
    logic [15:0] sport32, dport32, ulen32, dc32;

    inet_udp_rx_parser #(.DATA_W(32), .CNT_W(16)) dut32 (
        .clk(clk), .reset_n(reset_n), .s_tdata(d32), .s_tvalid(v32), .s_tready(r32),
        .s_tlast(l32), .m_tdata(md32), .m_tvalid(mv32), .m_tready(mr), .m_tlast(ml32),
        .hdr_valid(hv32), .hdr_dst_mac(dmac32), .hdr_src_mac(smac32), .hdr_src_ip(sip32),
        .hdr_dst_ip(dip32), .hdr_src_port(sport32), .hdr_dst_port(dport32),
        .hdr_udp_len(ulen32), .drop_pulse(dp32), .drop_cnt(dc32)
    );

    // DATA_W=16 instance
    logic [15:0] d16 = '0, md16;
    logic v16 = 0, l16 = 0, r16, mv16, ml16, hv16, dp16;
    logic mr_one = 1'b1;
    logic [47:0] dmac16, smac16;
    logic [31:0] sip16, dip16;
    logic [15:0] sport16, dport16, ulen16, dc16;

    inet_udp_rx_parser #(.DATA_W(16), .CNT_W(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .s_tdata(d16), .s_tvalid(v16), .s_tready(r16),
        .s_tlast(l16), .m_tdata(md16), .m_tvalid(mv16), .m_tready(mr_one), .m_tlast(ml16),
        .hdr_valid(hv16), .hdr_dst_mac(dmac16), .hdr_src_mac(smac16), .hdr_src_ip(sip16),
        .hdr_dst_ip(dip16), .hdr_src_port(sport16), .hdr_dst_port(dport16),
        .hdr_udp_len(ulen16), .drop_pulse(dp16), .drop_cnt(dc16)
    );

    // DATA_W=8 instance with a 2-bit drop counter
    logic [7:0] d8 = '0, md8;
    logic v8 = 0, l8 = 0, r8, mv8, ml8, hv8, dp8;
    logic [47:0] dmac8, smac8;
    logic [31:0] sip8, dip8;
    logic [15:0] sport8, dport8, ulen8;
    logic [1:0]  dc8;

    inet_udp_rx_parser #(.DATA_W(8), .CNT_W(2)) dut8 (
        .clk(clk), .reset_n(reset_n), .s_tdata(d8), .s_tvalid(v8), .s_tready(r8),
        .s_tlast(l8), .m_tdata(md8), .m_tvalid(mv8), .m_tready(mr_one), .m_tlast(ml8),
        .hdr_valid(hv8), .hdr_dst_mac(dmac8), .hdr_src_mac(smac8), .hdr_src_ip(sip8),
        .hdr_dst_ip(dip8), .hdr_src_port(sport8), .hdr_dst_port(dport8),
        .hdr_udp_len(ulen8), .drop_pulse(dp8), .drop_cnt(dc8)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Monitor state (sampled mid-cycle on the falling edge)
    logic        toggle = 1'b0;
    logic [7:0]  pay_q[$];
    logic [31:0] cap_sip[$], cap_dip[$];
    logic [15:0] cap_dport[$], cap_sport[$], cap_len[$];
    logic [47:0] cap_dmac[$], cap_smac[$];
    int mv_cyc, beats_n, n_last, last_at, hv_n, dp_n, hv16_n, hv8_n, dp8_n;
    logic [31:0] c16_sip, c8_sip;
    logic [15:0] c16_dport, c16_len, c8_dport, c8_len;
    logic [47:0] c16_dmac, c8_dmac;

    task automatic clear_mon();
        pay_q.delete(); cap_sip.delete(); cap_dip.delete(); cap_dport.delete();
        cap_sport.delete(); cap_len.delete(); cap_dmac.delete(); cap_smac.delete();
        mv_cyc = 0; beats_n = 0; n_last = 0; last_at = 0; hv_n = 0; dp_n = 0;
        hv16_n = 0; hv8_n = 0; dp8_n = 0;
    endtask

    initial forever begin
        @(negedge clk);
        if (mv32) mv_cyc++;
        if (mv32 && mr) begin
            for (int k = 0; k < 4; k++) pay_q.push_back(md32[8*k +: 8]);
            beats_n++;
            if (ml32) begin
                n_last++;
                last_at = beats_n;
            end
        end
        if (hv32) begin
            hv_n++;
            cap_sip.push_back(sip32); cap_dip.push_back(dip32);
            cap_dport.push_back(dport32); cap_sport.push_back(sport32);
            cap_len.push_back(ulen32); cap_dmac.push_back(dmac32); cap_smac.push_back(smac32);
        end
        if (dp32) dp_n++;
        if (hv16) begin
            hv16_n++; c16_sip = sip16; c16_dport = dport16; c16_len = ulen16; c16_dmac = dmac16;
        end
        if (hv8) begin
            hv8_n++; c8_sip = sip8; c8_dport = dport8; c8_len = ulen8; c8_dmac = dmac8;
        end
        if (dp8) dp8_n++;
    end

    // m_tready for the main instance: solid high, or alternating each cycle
    initial forever begin
        @(posedge clk);
        #1;
        mr = toggle ? ~mr : 1'b1;
    end

    // Frame under construction; padded with zeros to a 4-byte multiple
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];

    task automatic build(input int kind, input int pay, input logic [7:0] seed);
        logic [7:0] h [44];
        h = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h5e, 8'h01, 8'h01, 8'h01,
              8'h00, 8'h0a, 8'h35, 8'h00, 8'h01, 8'h02, 8'h08, 8'h00,
              8'h45, 8'h00, 8'h00, 8'h22, 8'hb9, 8'ha3, 8'h40, 8'h00,
              8'h01, 8'h11, 8'h05, 8'h7b, 8'hc0, 8'ha8, 8'h0a, 8'h02,
              8'hef, 8'h01, 8'h01, 8'h01, 8'hbe, 8'h98, 8'h23, 8'h82,
              8'h00, 8'h0e, 8'h3e, 8'he3};
        case (kind)
            1: begin h[14] = 8'h86; h[15] = 8'hdd; end
            2: h[25] = 8'h06;
            3: h[27] = 8'h7c;
            4: begin h[31] = 8'h03; h[27] = 8'h7a; h[39] = 8'h83; end
            default: ;
        endcase
        fq.delete();
        for (int i = 0; i < 44; i++) fq.push_back(h[i]);
        for (int i = 0; i < pay; i++) fq.push_back(seed + 8'(i));
        while (fq.size() % 4 != 0) fq.push_back(8'h00);
    endtask

    // Drive fq as beats of sel bytes onto the matching instance; tlast on the frame's last beat
    task automatic send(input int sel, input int max_beats);
        int beats, total, guard;
        logic [31:0] w;
        logic rdy, lst;
        total = fq.size() / sel;
        beats = (max_beats > 0 && max_beats < total) ? max_beats : total;
        for (int b = 0; b < beats; b++) begin
            w = '0;
            for (int k = 0; k < sel; k++) w[8*k +: 8] = fq[b*sel + k];
            lst = (b == total - 1);
            case (sel)
                4:       begin d32 = w;        v32 = 1'b1; l32 = lst; end
                2:       begin d16 = w[15:0];  v16 = 1'b1; l16 = lst; end
                default: begin d8  = w[7:0];   v8  = 1'b1; l8  = lst; end
            endcase
            guard = 0;
            rdy = 1'b0;
            while (!rdy && guard < 200) begin
                @(negedge clk);
                rdy = (sel == 4) ? r32 : (sel == 2) ? r16 : r8;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!rdy) begin
                n_fail++;
                $display("FAIL send_ready_timeout: s_tready stayed 0, required 1");
            end
        end
        v32 = 1'b0; l32 = 1'b0; v16 = 1'b0; l16 = 1'b0; v8 = 1'b0; l8 = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_payload(input string tag);
        check({tag, " payload_len"}, 64'(pay_q.size()), 64'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < pay_q.size(); j++) begin
            check($sformatf("%s payload_byte%0d", tag, j), 64'(pay_q[j]), 64'(exp_q[j]));
        end
    endtask

    typedef struct {
        int          kind;
        int          pay;
        bit          tgl;
        bit          ok;
        logic [31:0] sip;
        logic [15:0] dport;
    } vec_t;

    vec_t vt[7];
    int   exp_drop;

    initial begin
        vt[0] = '{kind: 0, pay: 6,  tgl: 1'b0, ok: 1'b1,     sip: 32'hc0a80a02, dport: 16'h2382};
        vt[1] = '{kind: 1, pay: 6,  tgl: 1'b0, ok: 1'b0,     sip: 32'hc0a80a02, dport: 16'h2382};
        vt[2] = '{kind: 2, pay: 6,  tgl: 1'b0, ok: 1'b0,     sip: 32'hc0a80a02, dport: 16'h2382};
        vt[3] = '{kind: 3, pay: 6,  tgl: 1'b0, ok: !CSUM_EN, sip: 32'hc0a80a02, dport: 16'h2382};
        vt[4] = '{kind: 0, pay: 6,  tgl: 1'b1, ok: 1'b1,     sip: 32'hc0a80a02, dport: 16'h2382};
        vt[5] = '{kind: 4, pay: 10, tgl: 1'b1, ok: 1'b1,     sip: 32'hc0a80a03, dport: 16'h2383};
        vt[6] = '{kind: 0, pay: 0,  tgl: 1'b0, ok: 1'b1,     sip: 32'hc0a80a02, dport: 16'h2382};
        exp_drop = 0;
        clear_mon();

        // Reset values
        d32 = 32'hdeadbeef;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst hdr_valid", hv32, 0);
        check("rst drop_pulse", dp32, 0);
        check("rst m_tvalid", mv32, 0);
        check("rst m_tlast", ml32, 0);
        check("rst drop_cnt", dc32, 0);
        check("rst src_ip", sip32, 0);
        check("rst dst_mac", dmac32, 0);
        check("rst m_tdata_passthru", md32, 64'hdeadbeef);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven frames on the 32-bit instance
        for (int i = 0; i < 7; i++) begin
            clear_mon();
            toggle = vt[i].tgl;
            build(vt[i].kind, vt[i].pay, 8'(16 * i + 1));
            exp_q.delete();
            if (vt[i].ok) for (int j = 44; j < fq.size(); j++) exp_q.push_back(fq[j]);
            send(4, 0);
            settle();
            toggle = 1'b0;
            if (!vt[i].ok) exp_drop++;
            check($sformatf("v%0d hdr_valid_cnt", i), 64'(hv_n), 64'(vt[i].ok));
            check($sformatf("v%0d drop_pulse_cnt", i), 64'(dp_n), 64'(!vt[i].ok));
            check($sformatf("v%0d drop_cnt", i), 64'(dc32), 64'(exp_drop));
            check($sformatf("v%0d m_tlast_cnt", i), 64'(n_last),
                  64'((vt[i].ok && vt[i].pay > 0) ? 1 : 0));
            check_payload($sformatf("v%0d", i));
            if (!vt[i].ok) check($sformatf("v%0d m_tvalid_cycles", i), 64'(mv_cyc), 0);
            if (vt[i].ok && vt[i].pay > 0)
                check($sformatf("v%0d m_tlast_pos", i), 64'(last_at), 64'(exp_q.size() / 4));
            if (vt[i].ok && hv_n > 0) begin
                check($sformatf("v%0d src_ip", i), 64'(cap_sip[0]), 64'(vt[i].sip));
                check($sformatf("v%0d dst_port", i), 64'(cap_dport[0]), 64'(vt[i].dport));
                check($sformatf("v%0d udp_len", i), 64'(cap_len[0]), 64'h000e);
                check($sformatf("v%0d src_port", i), 64'(cap_sport[0]), 64'hbe98);
                check($sformatf("v%0d dst_ip", i), 64'(cap_dip[0]), 64'hef010101);
                check($sformatf("v%0d dst_mac", i), 64'(cap_dmac[0]), 64'h01005e010101);
                check($sformatf("v%0d src_mac", i), 64'(cap_smac[0]), 64'h000a35000102);
            end
        end

        // Back-to-back frames with alternating m_tready
        clear_mon();
        toggle = 1'b1;
        exp_q.delete();
        build(0, 6, 8'h40);
        for (int j = 44; j < fq.size(); j++) exp_q.push_back(fq[j]);
        send(4, 0);
        build(4, 10, 8'h80);
        for (int j = 44; j < fq.size(); j++) exp_q.push_back(fq[j]);
        send(4, 0);
        settle();
        toggle = 1'b0;
        check("b2b hdr_valid_cnt", 64'(hv_n), 2);
        check("b2b m_tlast_cnt", 64'(n_last), 2);
        check("b2b beats", 64'(beats_n), 5);
        check_payload("b2b");
        if (hv_n == 2) begin
            check("b2b first src_ip", 64'(cap_sip[0]), 64'hc0a80a02);
            check("b2b second src_ip", 64'(cap_sip[1]), 64'hc0a80a03);
            check("b2b second dst_port", 64'(cap_dport[1]), 64'h2383);
        end

        // Runt frame (tlast on the 5th beat), then a good frame
        clear_mon();
        build(0, 0, 8'h00);
        fq = fq[0:19];
        send(4, 0);
        settle();
        exp_drop++;
        check("runt drop_pulse_cnt", 64'(dp_n), 1);
        check("runt hdr_valid_cnt", 64'(hv_n), 0);
        check("runt drop_cnt", 64'(dc32), 64'(exp_drop));
        clear_mon();
        build(4, 4, 8'h20);
        send(4, 0);
        settle();
        check("post_runt hdr_valid_cnt", 64'(hv_n), 1);
        if (hv_n > 0) check("post_runt src_ip", 64'(cap_sip[0]), 64'hc0a80a03);
        check("post_runt drop_cnt", 64'(dc32), 64'(exp_drop));

        // DATA_W=16 valid frame
        clear_mon();
        build(0, 6, 8'h30);
        send(2, 0);
        settle();
        check("w16 hdr_valid_cnt", 64'(hv16_n), 1);
        check("w16 src_ip", 64'(c16_sip), 64'hc0a80a02);
        check("w16 dst_port", 64'(c16_dport), 64'h2382);
        check("w16 udp_len", 64'(c16_len), 64'h000e);
        check("w16 dst_mac", 64'(c16_dmac), 64'h01005e010101);
        check("w16 drop_cnt", 64'(dc16), 0);

        // DATA_W=8 valid frame, then five bad frames into a 2-bit counter
        clear_mon();
        build(0, 6, 8'h50);
        send(1, 0);
        settle();
        check("w8 hdr_valid_cnt", 64'(hv8_n), 1);
        check("w8 src_ip", 64'(c8_sip), 64'hc0a80a02);
        check("w8 dst_port", 64'(c8_dport), 64'h2382);
        check("w8 udp_len", 64'(c8_len), 64'h000e);
        check("w8 dst_mac", 64'(c8_dmac), 64'h01005e010101);
        check("w8 drop_cnt_before", 64'(dc8), 0);
        for (int f = 0; f < 5; f++) begin
            build(1, 0, 8'h00);
            send(1, 0);
        end
        settle();
        check("sat drop_cnt", 64'(dc8), 3);
        check("sat drop_pulse_cnt", 64'(dp8_n), 5);
        check("sat hdr_valid_cnt", 64'(hv8_n), 1);

        // Reset in the middle of a payload
        clear_mon();
        build(0, 16, 8'h60);
        send(4, 12);
        d32 = {fq[51], fq[50], fq[49], fq[48]};
        v32 = 1'b1;
        @(negedge clk);
        check("midrst m_tvalid_before", mv32, 1);
        reset_n = 1'b0;
        v32 = 1'b0;
        @(negedge clk);
        check("midrst m_tvalid", mv32, 0);
        check("midrst m_tlast", ml32, 0);
        check("midrst hdr_valid", hv32, 0);
        check("midrst drop_pulse", dp32, 0);
        check("midrst drop_cnt", dc32, 0);
        check("midrst src_ip", sip32, 0);
        check("midrst dst_port", dport32, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_mon();
        fq = fq[48:$];
        send(4, 0);
        settle();
        check("midrst tail drop_cnt", 64'(dc32), 1);
        check("midrst tail drop_pulse_cnt", 64'(dp_n), 1);
        check("midrst tail hdr_valid_cnt", 64'(hv_n), 0);
        check("midrst tail m_tvalid_cycles", 64'(mv_cyc), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
